// File: rtl/rms_level_monitor.sv
// Turns the RMS detector's running power sum into a log2 level, a decaying peak-hold level,
// and debounced silence/overload alarms, one sample per word-clock cycle.
module rms_level_monitor #(
    parameter logic [47:0] SIL_THRESH = 48'd4096,
    parameter logic [47:0] SIL_EXIT   = 48'd16384,
    parameter logic [47:0] OVL_THRESH = 48'h0400_0000_0000,
    parameter int unsigned SIL_HOLD   = 48000,
    parameter int unsigned OVL_HOLD   = 24000,
    parameter int unsigned DECAY_DIV  = 1024
) (
    input  logic        wclk,
    input  logic        rst_n,
    input  logic [47:0] sum_rms,
    output logic [7:0]  level_log,
    output logic [7:0]  peak_log,
    output logic        silence,
    output logic        overload,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        NORMAL   = 2'd0,
        SIL_PEND = 2'd1,
        SILENCE  = 2'd2,
        OVERLOAD = 2'd3
    } state_e;

    localparam logic [23:0] SCNT_LAST = 24'(SIL_HOLD - 32'd2);
    localparam logic [23:0] OCNT_INIT = 24'(OVL_HOLD - 32'd1);
    localparam logic [15:0] DCNT_LAST = 16'(DECAY_DIV - 32'd1);

    logic [47:0] sum_q, sum_d;
    logic [7:0]  level_q, level_d;
    logic [7:0]  peak_q, peak_d;
    logic [7:0]  peak_dec;
    state_e      state_q, state_d;
    logic [23:0] scnt_q, scnt_d;
    logic [23:0] ocnt_q, ocnt_d;
    logic [15:0] dcnt_q, dcnt_d;
    logic        silence_q, overload_q;
    logic [5:0]  msb_idx;
    logic [1:0]  frac;

    // A set sign bit means the upstream delay FIFO is still filling; treat it as zero power.
    assign sum_d = sum_rms[47] ? 48'd0 : sum_rms;

    always_comb begin
        msb_idx = 6'd0;
        for (int i = 0; i < 48; i++) begin
            if (sum_q[i]) begin
                msb_idx = 6'(i);
            end
        end
        frac    = 2'({sum_q, 2'b00} >> msb_idx);
        level_d = (sum_q == 48'd0) ? 8'd0 : {msb_idx, frac};
    end

    always_comb begin
        state_d = state_q;
        scnt_d  = scnt_q;
        ocnt_d  = ocnt_q;
        if (sum_q > OVL_THRESH) begin
            state_d = OVERLOAD;
            ocnt_d  = OCNT_INIT;
        end else begin
            case (state_q)
                NORMAL: begin
                    if (sum_q < SIL_THRESH) begin
                        scnt_d = 24'd0;
                        if (SIL_HOLD == 1) begin
                            state_d = SILENCE;
                        end else begin
                            state_d = SIL_PEND;
                        end
                    end
                end
                SIL_PEND: begin
                    if (sum_q >= SIL_THRESH) begin
                        state_d = NORMAL;
                    end else if (scnt_q == SCNT_LAST) begin
                        state_d = SILENCE;
                    end else begin
                        scnt_d = scnt_q + 24'd1;
                    end
                end
                SILENCE: begin
                    if (sum_q >= SIL_EXIT) begin
                        state_d = NORMAL;
                    end
                end
                OVERLOAD: begin
                    if (ocnt_q == 24'd0) begin
                        state_d = NORMAL;
                    end else begin
                        ocnt_d = ocnt_q - 24'd1;
                    end
                end
                default: state_d = NORMAL;
            endcase
        end
    end

    // Decay never drops the peak below the level being registered this cycle.
    always_comb begin
        peak_d   = peak_q;
        dcnt_d   = dcnt_q + 16'd1;
        peak_dec = peak_q - 8'd1;
        if (level_d > peak_q) begin
            peak_d = level_d;
            dcnt_d = 16'd0;
        end else if (dcnt_q == DCNT_LAST) begin
            dcnt_d = 16'd0;
            if (peak_q != 8'd0) begin
                peak_d = (peak_dec > level_d) ? peak_dec : level_d;
            end
        end
    end

    always_ff @(posedge wclk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q      <= 48'd0;
            level_q    <= 8'd0;
            peak_q     <= 8'd0;
            state_q    <= NORMAL;
            scnt_q     <= 24'd0;
            ocnt_q     <= 24'd0;
            dcnt_q     <= 16'd0;
            silence_q  <= 1'b0;
            overload_q <= 1'b0;
        end else begin
            sum_q      <= sum_d;
            level_q    <= level_d;
            peak_q     <= peak_d;
            state_q    <= state_d;
            scnt_q     <= scnt_d;
            ocnt_q     <= ocnt_d;
            dcnt_q     <= dcnt_d;
            silence_q  <= (state_d == SILENCE);
            overload_q <= (state_d == OVERLOAD);
        end
    end

    assign level_log = level_q;
    assign peak_log  = peak_q;
    assign silence   = silence_q;
    assign overload  = overload_q;
    assign state     = state_q;

endmodule

// File: tb/tb_rms_level_monitor.sv
// Directed bench for rms_level_monitor with short hold/decay parameters and hand-computed expectations.
module tb_rms_level_monitor;

    localparam logic [47:0] OVL = 48'h0400_0000_0000;

    logic        wclk = 1'b0;
    logic        rst_n = 1'b0;
    logic [47:0] sum_rms = 48'd0;
    logic [7:0]  level_log;
    logic [7:0]  peak_log;
    logic        silence;
    logic        overload;
    logic [1:0]  state;

    int checkCount = 0;
    int errorCount = 0;

    rms_level_monitor #(
        .SIL_THRESH(48'd4096),
        .SIL_EXIT  (48'd16384),
        .OVL_THRESH(OVL),
        .SIL_HOLD  (8),
        .OVL_HOLD  (4),
        .DECAY_DIV (4)
    ) dut (
        .wclk     (wclk),
        .rst_n    (rst_n),
        .sum_rms  (sum_rms),
        .level_log(level_log),
        .peak_log (peak_log),
        .silence  (silence),
        .overload (overload),
        .state    (state)
    );

    always #5 wclk = ~wclk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [47:0] value);
        sum_rms = value;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge wclk);
        #1;
    endtask

    task automatic checkAlarms(input string tag, input logic [1:0] expState);
        checkOutput({tag, "_state"}, 64'(state), 64'(expState));
        checkOutput({tag, "_silence"}, 64'(silence), 64'(expState == 2'd2));
        checkOutput({tag, "_overload"}, 64'(overload), 64'(expState == 2'd3));
    endtask

    logic [47:0] levelIn  [8] = '{48'd1, 48'd2, 48'd3, 48'h1C00, 48'd0,
                                  48'h7FFF_FFFF_FFFF, 48'h8000_0000_0001, 48'hC0};
    logic [7:0]  levelExp [8] = '{8'h00, 8'h04, 8'h06, 8'h33, 8'h00, 8'hBB, 8'h00, 8'h1E};

    initial begin
        // Reset with a negative (bit47) input present, then release mid-stream.
        applyStimulus(48'hFFFF_FFFF_FFFF);
        step(3);
        checkAlarms("in_reset", 2'd0);
        checkOutput("in_reset_level", 64'(level_log), 64'h0);
        checkOutput("in_reset_peak", 64'(peak_log), 64'h0);
        rst_n = 1'b1;
        #2;
        checkAlarms("released", 2'd0);
        step(2);
        checkOutput("clamp_level", 64'(level_log), 64'h0);
        checkAlarms("clamp", 2'd1);

        applyStimulus(48'd20000);
        step(2);
        checkAlarms("normal", 2'd0);

        // Silence entry and hysteretic exit.
        applyStimulus(48'd100);
        step(2);
        checkAlarms("sil_pend", 2'd1);
        checkOutput("level_100", 64'(level_log), 64'h1A);
        step(6);
        checkAlarms("sil_pend_late", 2'd1);
        step(1);
        checkAlarms("sil_entered", 2'd2);
        applyStimulus(48'd8000);
        step(4);
        checkAlarms("sil_hold_8000", 2'd2);
        applyStimulus(48'd16383);
        step(3);
        checkAlarms("sil_hold_16383", 2'd2);
        applyStimulus(48'd16384);
        step(1);
        checkAlarms("sil_exit_lag", 2'd2);
        step(1);
        checkAlarms("sil_exit", 2'd0);

        // Short dip must not reach silence.
        applyStimulus(48'd100);
        for (int i = 0; i < 5; i++) begin
            step(1);
            checkOutput("glitch_silence", 64'(silence), 64'h0);
        end
        applyStimulus(48'd5000);
        step(1);
        checkAlarms("glitch_pend", 2'd1);
        step(1);
        checkAlarms("glitch_back", 2'd0);
        applyStimulus(48'd4096);
        step(3);
        checkAlarms("thresh_exact", 2'd0);

        // Exactly at the overload threshold is not overload.
        applyStimulus(OVL);
        step(1);
        applyStimulus(48'd20000);
        for (int i = 0; i < 3; i++) begin
            step(1);
            checkAlarms("ovl_exact", 2'd0);
        end

        // Single pulse: overload for exactly four cycles.
        applyStimulus(OVL + 48'd1);
        step(1);
        checkOutput("ovl_pre", 64'(overload), 64'h0);
        applyStimulus(48'd20000);
        for (int i = 0; i < 4; i++) begin
            step(1);
            checkAlarms("ovl_hang", 2'd3);
        end
        step(1);
        checkAlarms("ovl_release", 2'd0);

        // Second pulse during the hang restarts it.
        applyStimulus(OVL + 48'd1);
        step(1);
        applyStimulus(48'd20000);
        step(2);
        checkAlarms("ovl_first", 2'd3);
        applyStimulus(OVL + 48'd1);
        step(1);
        applyStimulus(48'd20000);
        step(1);
        for (int i = 0; i < 3; i++) begin
            step(1);
            checkAlarms("ovl_extended", 2'd3);
        end
        step(1);
        checkAlarms("ovl_ext_release", 2'd0);

        // Asynchronous reset in the middle of an overload hang.
        applyStimulus(OVL + 48'd1);
        step(1);
        applyStimulus(48'd20000);
        step(2);
        checkAlarms("ovl_before_reset", 2'd3);
        #3;
        rst_n = 1'b0;
        #1;
        checkAlarms("async_reset", 2'd0);
        checkOutput("async_reset_peak", 64'(peak_log), 64'h0);
        checkOutput("async_reset_level", 64'(level_log), 64'h0);
        step(2);
        rst_n = 1'b1;

        // Level encoding table.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(levelIn[i]);
            step(2);
            checkOutput($sformatf("level_%0d", i), 64'(level_log), 64'(levelExp[i]));
        end

        // Peak load then decay by one LSB every four cycles down to zero.
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        applyStimulus(48'h1C00);
        step(1);
        checkOutput("peak_start", 64'(peak_log), 64'h0);
        step(1);
        checkOutput("peak_load", 64'(peak_log), 64'h33);
        applyStimulus(48'd0);
        step(3);
        checkOutput("peak_hold", 64'(peak_log), 64'h33);
        for (int v = 8'h32; v >= 0; v--) begin
            step(1);
            checkOutput("peak_decay", 64'(peak_log), 64'(v));
            step(3);
            checkOutput("peak_decay_hold", 64'(peak_log), 64'(v));
        end
        step(8);
        checkOutput("peak_floor", 64'(peak_log), 64'h0);
        checkOutput("level_zero", 64'(level_log), 64'h0);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
